// File: rtl/timer_arbiter_if.sv
// Request/grant bundle between the requesters and the shared tick timer.
// The requester side (master) drives req/len; the timer side (slave)
// reports ownership, completion, the timebase tick and the live count.
interface timer_arbiter_if #(
  parameter int CNT_W = 16
);
  logic [3:0]         req;
  logic [4*CNT_W-1:0] len;
  logic [3:0]         grant;
  logic [3:0]         done;
  logic               tick;
  logic               busy;
  logic [CNT_W-1:0]   remaining;

  modport master (
    output req, len,
    input  grant, done, tick, busy, remaining
  );

  modport slave (
    input  req, len,
    output grant, done, tick, busy, remaining
  );
endinterface

// File: rtl/timer_arbiter.sv
// Shared down-counting timer arbitrated round-robin among four requesters.
// The owner gets len ticks of a PRESCALE-divided timebase, then a one-cycle
// done pulse. Dropping its request mid-run aborts silently. Between owners
// the block always passes through one IDLE cycle with grant low.
module timer_arbiter #(
  parameter int PRESCALE = 262144,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  timer_arbiter_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [1:0]       last_r;
  logic [1:0]       owner_r;
  logic [3:0]       grant_r;
  logic [PW-1:0]    presc_r;
  logic [CNT_W-1:0] cnt_r;

  logic [1:0]       pick_s;
  logic [3:0]       pick_oh_s;
  logic [CNT_W-1:0] pick_len_s;
  logic             owner_req_s;
  logic             tick_s;

  // Round-robin search starting just after the previous owner.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v,
                                         input logic [1:0] last_v);
    logic [1:0] idx;
    logic       found;
    rr_pick = last_v;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_v + 2'(i);
      if (!found && req_v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  // Candidate owner, its one-hot grant and its requested length.
  always_comb begin
    pick_s      = rr_pick(bus.req, last_r);
    pick_oh_s   = 4'b0001 << pick_s;
    pick_len_s  = {CNT_W{1'b0}};
    case (pick_s)
      2'd0:    pick_len_s = bus.len[0*CNT_W +: CNT_W];
      2'd1:    pick_len_s = bus.len[1*CNT_W +: CNT_W];
      2'd2:    pick_len_s = bus.len[2*CNT_W +: CNT_W];
      2'd3:    pick_len_s = bus.len[3*CNT_W +: CNT_W];
      default: pick_len_s = {CNT_W{1'b0}};
    endcase
    owner_req_s = bus.req[owner_r];
  end

  // Tick is a pure decode of the registered state and prescaler.
  always_comb begin
    if ((state_r == ST_RUN) && (presc_r == PS_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Main FSM: selection, prescaled countdown, abort and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      last_r  <= 2'd3;
      owner_r <= 2'd0;
      grant_r <= 4'b0000;
      presc_r <= {PW{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req != 4'b0000) begin
            owner_r <= pick_s;
            grant_r <= pick_oh_s;
            cnt_r   <= pick_len_s;
            presc_r <= {PW{1'b0}};
            if (pick_len_s != {CNT_W{1'b0}}) begin
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_DONE;
            end
          end else begin
            grant_r <= 4'b0000;
          end
        end
        ST_RUN: begin
          // A dropped owner request wins over a completing tick.
          if (!owner_req_s) begin
            state_r <= ST_IDLE;
            last_r  <= owner_r;
            grant_r <= 4'b0000;
            presc_r <= {PW{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
          end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
            if (cnt_r == CNT_W'(1)) begin
              state_r <= ST_DONE;
              cnt_r   <= {CNT_W{1'b0}};
            end else begin
              cnt_r   <= cnt_r - CNT_W'(1);
            end
          end else begin
            presc_r <= presc_r + PW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          last_r  <= owner_r;
          grant_r <= 4'b0000;
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= 4'b0000;
          presc_r <= {PW{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.grant     = grant_r;
  assign bus.done      = (state_r == ST_DONE) ? grant_r : 4'b0000;
  assign bus.tick      = tick_s;
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.remaining = cnt_r;

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter PRESCALE, default 262144, meaning clk cycles per timebase tick (legal range >= 1).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each requested tick count.
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  4  per-requester level request, held high until done or abandoned.
REQ-006 SHALL have port len  input  4*CNT_W  requested tick counts; requester i uses len[i*CNT_W +: CNT_W].
REQ-007 SHALL have port grant  output  4  one-hot owner of the shared timer, or all zero.
REQ-008 SHALL have port done  output  4  one-cycle completion pulse to the owning requester.
REQ-009 SHALL have port tick  output  1  one-cycle timebase tick pulse, asserted only in RUN.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port remaining  output  CNT_W  current tick down-counter value.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE, with all outputs registered or decoded from registered state.
REQ-013 SHALL, in IDLE with req != 0, select owner g by round-robin: search indices last+1, last+2, ... mod 4 and take the first with req high.
REQ-014 SHALL, on the selecting edge, latch g, load the counter from len[g] and clear the prescaler.
REQ-015 SHALL, on that same edge, go to RUN if len[g] != 0 and to DONE if len[g] == 0.
REQ-016 SHALL hold grant[g] high throughout RUN and DONE, and drive grant = 0 in IDLE.
REQ-017 SHALL, in RUN, advance the prescaler 0..PRESCALE-1 and wrap to 0; tick is high in the cycle where the prescaler equals PRESCALE-1.
REQ-018 SHALL, on a tick edge, decrement the counter; if the counter equals 1 on that tick, the state goes to DONE and the counter to 0.
REQ-019 SHALL timestamp completion as follows: with the first grant-high cycle numbered 1, done[g] is high in cycle len*PRESCALE+1 only.
REQ-020 SHALL, in DONE, pulse done[g] for exactly one cycle, set last = g, and return to IDLE on the next edge.
REQ-021 SHALL, in DONE, not grant a new owner in that cycle; a new owner may be granted no earlier than the following IDLE cycle.
REQ-022 SHALL treat req[g] low during RUN as an abort:
- next edge: go to IDLE, set last = g, drive grant to 0;
- no done pulse is produced.
REQ-023 SHALL give abort priority over a completing tick in the same cycle.
REQ-024 SHALL ignore req changes of non-owners while busy; their requests are evaluated only in IDLE.
REQ-025 SHALL treat req[g] still high in the IDLE cycle after DONE as a new request, subject to round-robin order.
REQ-026 SHALL ignore len changes after the selecting edge.
REQ-027 SHALL, when PRESCALE = 1, assert tick in every RUN cycle.

Reset
REQ-028 SHALL, when rst is high at a clock edge, set the following and override all other activity, including mid-RUN:
- state = IDLE, last = 3;
- prescaler = 0, counter = 0;
- grant = 0, done = 0, tick = 0, busy = 0, remaining = 0.

Verification
All scenarios use PRESCALE = 4 and CNT_W = 16.
REQ-029 SHALL cover reset: rst high 2 cycles with req = 1111 -> all outputs 0; after release, the first grant is 0001.
REQ-030 SHALL cover a single timed request: req = 0001, len0 = 3 -> grant = 0001 one cycle later; tick every 4th cycle; remaining 3,2,1,0; done = 0001 in cycle 13 of grant.
REQ-031 SHALL cover round-robin: req = 1111 held, all len = 1 -> grant sequence 0001, 0010, 0100, 1000, 0001, each ending in a done pulse.
REQ-032 SHALL cover zero length: req = 0100, len2 = 0 -> grant = 0100 and done = 0100 in the same single cycle, no tick, busy for 1 cycle.
REQ-033 SHALL cover abort: req = 0011, len1 = 5, with req[1] dropped during the third tick period:
- if owner is 1: grant = 0 next cycle, no done[1], then grant = 0001;
- with last = 0 before the scenario, owner is 1.
REQ-034 SHALL cover reset mid-RUN: rst asserted during RUN with remaining = 2 -> next cycle grant = 0, busy = 0, remaining = 0, no done pulse.
